// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Sequential 32-bit integer divider for the execute stage. Radix-2 restoring
// algorithm, one quotient bit per cycle, signed or unsigned. Returns
// {remainder, quotient} on a 64-bit bus for the HI/LO registers.
//
// Ports:
//   clk           in   1   clock, rising edge
//   resetn        in   1   synchronous, active-low reset
//   div_sign      in   1   1 = signed divide, 0 = unsigned (sampled with start)
//   div_start_i   in   1   start request, accepted only when idle
//   div_cancel_i  in   1   abort the in-flight divide (pipeline flush)
//   div_op1       in  32   dividend (sampled with start)
//   div_op2       in  32   divisor  (sampled with start)
//   result        out 64   {remainder, quotient}, held between completions
//   div_ready_o   out  1   one-cycle pulse when result is updated
//   div_busy_o    out  1   high while a divide is in flight
//   div_zero_o    out  1   (DIV_ZERO_DETECT_EN only) pulses with div_ready_o
//                          when the divisor was zero
//
// Configuration macro: DIV_ZERO_DETECT_EN
//   Defined: zero divisors skip the iteration loop and complete one cycle
//   after acceptance with result {op1, 32'hFFFFFFFF}, flagged on div_zero_o.
//   Undefined: zero divisors run the full loop; the restoring algorithm then
//   yields the architectural divide-by-zero values naturally.
//
// Handshake: a start is taken on any rising edge where div_start_i=1 and the
// unit is idle (div_busy_o=0); operands and div_sign are captured on that edge
// and later input changes are ignored. Completion is signalled by a single
// cycle div_ready_o pulse, during which the unit is already idle and can take
// the next start. A cancel while busy returns to idle with no ready pulse and
// leaves result untouched.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_sign,
    input  logic        div_start_i,
    input  logic        div_cancel_i,
    input  logic [31:0] div_op1,
    input  logic [31:0] div_op2,
    output logic [63:0] result,
    output logic        div_ready_o,
`ifdef DIV_ZERO_DETECT_EN
    output logic        div_zero_o,
`endif
    output logic        div_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rem_q, rem_d;        // partial remainder
    logic [31:0] quo_q, quo_d;        // dividend shifting out / quotient shifting in
    logic [31:0] dvs_q, dvs_d;        // |divisor|
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
`ifdef DIV_ZERO_DETECT_EN
    logic        dz_q, dz_d;          // current divide has a zero divisor
    logic        zero_q, zero_d;
`endif

    logic        op1_neg, op2_neg;
    logic [31:0] op1_abs, op2_abs;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    // Datapath helpers
    always_comb begin
        op1_neg = div_sign & div_op1[31];
        op2_neg = div_sign & div_op2[31];
        op1_abs = op1_neg ? (~div_op1 + 32'd1) : div_op1;
        op2_abs = op2_neg ? (~div_op2 + 32'd1) : div_op2;
        // {rem,quo} shifted left by one; the dividend MSB enters the remainder.
        // The remainder is always below the divisor, so 33 bits cannot
        // overflow and trial[32] is a true sign bit.
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
        // Quotient sign = XOR of operand signs; remainder follows the dividend.
        quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        dz_d      = dz_q;
        zero_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (div_start_i) begin
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    dvs_d     = op2_abs;
                    rem_d     = 32'd0;
                    quo_d     = op1_abs;
                    cnt_d     = 5'd0;
                    state_d   = S_CALC;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d = (div_op2 == 32'd0);
                    if (div_op2 == 32'd0) begin
                        // Preload the final values so FIX only has to copy
                        // them out: raw op1 as remainder, all-ones quotient,
                        // no sign correction.
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        rem_d     = div_op1;
                        quo_d     = 32'hFFFF_FFFF;
                        state_d   = S_FIX;
                    end
`endif
                end
            end

            S_CALC: begin
                if (div_cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                // Cancel wins over completion: result and ready stay quiet.
                if (!div_cancel_i) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    zero_d   = dz_q;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= 1'b0;
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q      <= dz_d;
            zero_q    <= zero_d;
`endif
        end
    end

    assign result      = result_q;
    assign div_ready_o = ready_q;
    assign div_busy_o  = (state_q != S_IDLE);
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero_o  = zero_q;
`endif

endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-bit integer divider for the execute stage, the inverse companion of the multiplier: takes a dividend/divisor pair on a start strobe, runs a radix-2 restoring loop of one quotient bit per cycle, and returns {remainder, quotient} on a 64-bit bus for the HI/LO registers. It supports signed and unsigned division, holds its result until the next completion, and accepts a cancel from the pipeline flush logic.

## Interface
Parameters: none (width fixed at 32).

- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  reset, synchronous, active-low
- div_sign  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
- div_start_i  in  1  start request; accepted only in IDLE
- div_cancel_i  in  1  abort in-flight operation (pipeline flush)
- div_op1  in  32  dividend; sampled with start
- div_op2  in  32  divisor; sampled with start
- result  out  64  {remainder[63:32], quotient[31:0]}; registered, held between completions
- div_ready_o  out  1  one-cycle pulse: result updated this cycle
- div_busy_o  out  1  high while in CALC or FIX

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on edge with div_start_i=1, latch sign flags (op1[31]&div_sign, op2[31]&div_sign), latch absolute values of both operands (negate when flag set), clear the 32-bit partial remainder, load the dividend into the quotient shift register, set count=0, and go to CALC.
- CALC, each edge: shift {rem,quo} left 1; trial = rem_shifted − |divisor| at 33 bits; if trial ≥ 0, rem=trial and quo LSB=1; otherwise keep the shifted remainder and set quo LSB=0; count++. After the 32nd iteration (count=31 on entry), go to FIX.
- FIX: quotient negated if the dividend and divisor sign flags differ. Remainder negated if the dividend flag is set, so the remainder takes the sign of the dividend. Register these into result, set div_ready_o=1, go to IDLE.
- Unsigned divide by zero: quotient 0xFFFFFFFF, remainder = op1.
- Signed divide by zero: remainder = op1; quotient 0xFFFFFFFF if op1 ≥ 0, else 0x00000001.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is natural wrap and is not flagged.
- div_start_i in CALC/FIX is ignored. Operand changes after acceptance are ignored.
- div_cancel_i=1 in CALC or FIX: go to IDLE on the next edge. No ready pulse, and result is unchanged. Cancel has priority over FIX completion. Cancel in IDLE has no effect, and a start on the same edge is still accepted.

## Timing
- Reset values: result=0, div_ready_o=0, div_busy_o=0, state=IDLE, all internal registers 0. Reset mid-operation aborts with no ready pulse.
- Start accepted at edge E0. CALC runs on E1..E32 and FIX on E33. div_ready_o and the new result are visible after E33, 33 cycles after acceptance. div_ready_o clears at E34.
- div_busy_o is high from after E0 until after E33.
- Back-to-back: a start sampled at E34, while div_ready_o is high, is accepted. Throughput is one divide per 34 cycles.
- No combinational path from inputs to outputs.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - Adds output div_zero_o (1 bit, reset 0).
  - A start with div_op2=0 goes straight from IDLE to FIX. At E1 result={op1, 32'hFFFFFFFF} regardless of div_sign, div_ready_o=1, div_zero_o=1. Both flags pulse together for one cycle.
  - Other divides are unaffected, and div_zero_o stays 0.
- Not defined:
  - No div_zero_o port.
  - Zero divisors run the full 33-cycle path and produce the divide-by-zero values from Operation.

## Test plan
- Unsigned 100/7, div_sign=0 → result={32'd2, 32'd14}; ready pulse exactly 33 cycles after start; busy high for 33 cycles.
- Signed −7/2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 1.
- Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}. Signed 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
- Cancel at cycle 10 of CALC, with prior result 0x0000000200000005 → no ready pulse, result unchanged, busy low after the next edge. A start one cycle later completes normally.
- Divide 9/0 signed and unsigned → with DIV_ZERO_DETECT_EN: ready and div_zero_o pulse 1 cycle after start, result {9, 0xFFFFFFFF}. Without the macro: ready at 33 cycles, same value.
- Start held high continuously with new operands each time → every accepted op completes 34 cycles apart. Starts during busy are ignored. Reset asserted mid-CALC → all outputs 0 on the next edge.
